// File: rtl/pep_ks_common_param_pkg.sv
// Parameters, helpers and FSM state type shared between the BLWE load feeder
// and the key-switch control.
package pep_ks_common_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } ldb_state_e;

    function automatic int calc_beat_nb(input int coef_nb, input int beat_coef);
        return (coef_nb + beat_coef - 1) / beat_coef;
    endfunction

    // Valid coefficients in the final beat, always within 1..beat_coef.
    function automatic int calc_last_coef(input int coef_nb, input int beat_coef);
        return coef_nb - (calc_beat_nb(coef_nb, beat_coef) - 1) * beat_coef;
    endfunction

    localparam int DEF_MOD_Q_W       = 32;
    localparam int DEF_PID_W         = 5;
    localparam int DEF_KS_IF_SUBW_NB = 2;
    localparam int DEF_KS_IF_COEF_NB = 4;
    localparam int DEF_BLWE_COEF_NB  = 2049;
    localparam int DEF_BEAT_COEF     = DEF_KS_IF_SUBW_NB * DEF_KS_IF_COEF_NB;
    localparam int BEAT_NB           = calc_beat_nb(DEF_BLWE_COEF_NB, DEF_BEAT_COEF);
    localparam int LAST_COEF         = calc_last_coef(DEF_BLWE_COEF_NB, DEF_BEAT_COEF);

endpackage

// File: rtl/pep_ldb_last_mask.sv
// Constant masks for the final beat of a ciphertext: which sub-words are
// written and which coefficient lanes keep their data.
module pep_ldb_last_mask
    import pep_ks_common_param_pkg::*;
#(
    parameter int MOD_Q_W       = 32,
    parameter int KS_IF_SUBW_NB = 2,
    parameter int KS_IF_COEF_NB = 4,
    parameter int LAST_COEF     = 1
) (
    output logic [KS_IF_SUBW_NB-1:0]                       wr_en_mask,
    output logic [KS_IF_SUBW_NB*KS_IF_COEF_NB*MOD_Q_W-1:0] lane_bit_mask
);

    localparam int BEAT_COEF = KS_IF_SUBW_NB * KS_IF_COEF_NB;

    for (genvar s = 0; s < KS_IF_SUBW_NB; s++) begin : g_subw
        assign wr_en_mask[s] = (s * KS_IF_COEF_NB < LAST_COEF);
    end

    for (genvar i = 0; i < BEAT_COEF; i++) begin : g_lane
        assign lane_bit_mask[i*MOD_Q_W +: MOD_Q_W] = (i < LAST_COEF) ? '1 : '0;
    end

endmodule

// File: rtl/pep_ldb_blram_feeder.sv
// Loads one BLWE per command from the beat stream into the key-switch BLWE RAM
// write port, flags the final beat and reports completion with the PID.
module pep_ldb_blram_feeder
    import pep_ks_common_param_pkg::*;
#(
    parameter int MOD_Q_W       = 32,
    parameter int PID_W         = 5,
    parameter int KS_IF_SUBW_NB = 2,
    parameter int KS_IF_COEF_NB = 4,
    parameter int BLWE_COEF_NB  = 2049
) (
    input  logic                                             clk,
    input  logic                                             s_rst_n,
    input  logic [PID_W-1:0]                                 cmd_pid,
    input  logic                                             cmd_vld,
    output logic                                             cmd_rdy,
    input  logic [KS_IF_SUBW_NB*KS_IF_COEF_NB*MOD_Q_W-1:0]   in_data,
    input  logic                                             in_vld,
    output logic                                             in_rdy,
    output logic [KS_IF_SUBW_NB-1:0]                         ldb_blram_wr_en,
    output logic [KS_IF_SUBW_NB*PID_W-1:0]                   ldb_blram_wr_pid,
    output logic [KS_IF_SUBW_NB*KS_IF_COEF_NB*MOD_Q_W-1:0]   ldb_blram_wr_data,
    output logic [KS_IF_SUBW_NB-1:0]                         ldb_blram_wr_pbs_last,
    output logic [PID_W-1:0]                                 ldb_done_pid,
    output logic                                             ldb_done,
    output logic                                             error_in_ovf
);

    localparam int BEAT_COEF   = KS_IF_SUBW_NB * KS_IF_COEF_NB;
    localparam int DATA_W      = BEAT_COEF * MOD_Q_W;
    localparam int BEAT_NB_L   = calc_beat_nb(BLWE_COEF_NB, BEAT_COEF);
    localparam int LAST_COEF_L = calc_last_coef(BLWE_COEF_NB, BEAT_COEF);
    localparam int CNT_W       = $clog2(BEAT_NB_L + 1);

    logic [KS_IF_SUBW_NB-1:0] last_en_mask;
    logic [DATA_W-1:0]        last_lane_mask;

    pep_ldb_last_mask #(
        .MOD_Q_W       (MOD_Q_W),
        .KS_IF_SUBW_NB (KS_IF_SUBW_NB),
        .KS_IF_COEF_NB (KS_IF_COEF_NB),
        .LAST_COEF     (LAST_COEF_L)
    ) u_last_mask (
        .wr_en_mask    (last_en_mask),
        .lane_bit_mask (last_lane_mask)
    );

    ldb_state_e                 state_q, state_d;
    logic [PID_W-1:0]           pid_q, pid_d;
    logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic                       cmd_rdy_q, cmd_rdy_d;
    logic                       in_rdy_q, in_rdy_d;
    logic [KS_IF_SUBW_NB-1:0]   wr_en_q, wr_en_d;
    logic [KS_IF_SUBW_NB*PID_W-1:0] wr_pid_q, wr_pid_d;
    logic [DATA_W-1:0]          wr_data_q, wr_data_d;
    logic [KS_IF_SUBW_NB-1:0]   wr_pbs_last_q, wr_pbs_last_d;
    logic [PID_W-1:0]           done_pid_q, done_pid_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;

    logic beat_acc;
    logic last_beat;

    assign beat_acc  = in_vld & in_rdy_q;
    assign last_beat = (beat_cnt_q == CNT_W'(BEAT_NB_L - 1));

    always_comb begin
        state_d       = state_q;
        pid_d         = pid_q;
        beat_cnt_d    = beat_cnt_q;
        wr_en_d       = '0;
        wr_pid_d      = wr_pid_q;
        wr_data_d     = wr_data_q;
        wr_pbs_last_d = '0;
        done_pid_d    = done_pid_q;
        done_d        = 1'b0;
        error_d       = error_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_vld && cmd_rdy_q) begin
                    pid_d      = cmd_pid;
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat_acc) begin
                    beat_cnt_d       = beat_cnt_q + CNT_W'(1);
                    wr_en_d          = last_beat ? last_en_mask : '1;
                    wr_data_d        = last_beat ? (in_data & last_lane_mask) : in_data;
                    wr_pid_d         = {KS_IF_SUBW_NB{pid_q}};
                    wr_pbs_last_d[0] = last_beat;
                    if (last_beat) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        done_pid_d = pid_q;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Stray beats are left unconsumed; only the sticky flag records them.
        if (in_vld && (state_q != ST_XFER)) begin
            error_d = 1'b1;
        end

        cmd_rdy_d = (state_d == ST_IDLE);
        in_rdy_d  = (state_d == ST_XFER);
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q       <= ST_IDLE;
            pid_q         <= '0;
            beat_cnt_q    <= '0;
            cmd_rdy_q     <= 1'b0;
            in_rdy_q      <= 1'b0;
            wr_en_q       <= '0;
            wr_pid_q      <= '0;
            wr_data_q     <= '0;
            wr_pbs_last_q <= '0;
            done_pid_q    <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pid_q         <= pid_d;
            beat_cnt_q    <= beat_cnt_d;
            cmd_rdy_q     <= cmd_rdy_d;
            in_rdy_q      <= in_rdy_d;
            wr_en_q       <= wr_en_d;
            wr_pid_q      <= wr_pid_d;
            wr_data_q     <= wr_data_d;
            wr_pbs_last_q <= wr_pbs_last_d;
            done_pid_q    <= done_pid_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign cmd_rdy               = cmd_rdy_q;
    assign in_rdy                = in_rdy_q;
    assign ldb_blram_wr_en       = wr_en_q;
    assign ldb_blram_wr_pid      = wr_pid_q;
    assign ldb_blram_wr_data     = wr_data_q;
    assign ldb_blram_wr_pbs_last = wr_pbs_last_q;
    assign ldb_done_pid          = done_pid_q;
    assign ldb_done              = done_q;
    assign error_in_ovf          = error_q;

endmodule

// File: tb/tb_pep_ldb_blram_feeder.sv
// Scoreboard bench: two feeders (10 and 16 coefficients per BLWE) share one
// stimulus stream; each has its own expected-write and expected-done queues.
module tb_pep_ldb_blram_feeder;

    localparam int DW = 256;
    localparam logic [DW-1:0] MASK10 = {{192{1'b0}}, {64{1'b1}}};

    typedef struct {
        logic [1:0]    en;
        logic [9:0]    pid;
        logic [DW-1:0] data;
        logic [1:0]    last;
        int            cyc;
    } wr_exp_t;

    typedef struct {
        logic [4:0] pid;
        int         cyc;
    } done_exp_t;

    logic          clk;
    logic          s_rst_n;
    logic [4:0]    cmd_pid;
    logic          cmd_vld;
    logic [DW-1:0] in_data;
    logic          in_vld;

    logic          cmd_rdy, in_rdy, done10, err10;
    logic [1:0]    wen10, wlast10;
    logic [9:0]    wpid10;
    logic [DW-1:0] wdata10;
    logic [4:0]    dpid10;

    logic          cmd_rdy16, in_rdy16, done16, err16;
    logic [1:0]    wen16, wlast16;
    logic [9:0]    wpid16;
    logic [DW-1:0] wdata16;
    logic [4:0]    dpid16;

    int checks = 0;
    int failures = 0;
    int cycle_cnt = 0;

    wr_exp_t   q10[$];
    wr_exp_t   q16[$];
    done_exp_t dq10[$];
    done_exp_t dq16[$];
    int        done_cycles[$];

    pep_ldb_blram_feeder #(.BLWE_COEF_NB(10)) u_dut (
        .clk(clk), .s_rst_n(s_rst_n),
        .cmd_pid(cmd_pid), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .ldb_blram_wr_en(wen10), .ldb_blram_wr_pid(wpid10),
        .ldb_blram_wr_data(wdata10), .ldb_blram_wr_pbs_last(wlast10),
        .ldb_done_pid(dpid10), .ldb_done(done10), .error_in_ovf(err10)
    );

    pep_ldb_blram_feeder #(.BLWE_COEF_NB(16)) u_dut16 (
        .clk(clk), .s_rst_n(s_rst_n),
        .cmd_pid(cmd_pid), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy16),
        .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy16),
        .ldb_blram_wr_en(wen16), .ldb_blram_wr_pid(wpid16),
        .ldb_blram_wr_data(wdata16), .ldb_blram_wr_pbs_last(wlast16),
        .ldb_done_pid(dpid16), .ldb_done(done16), .error_in_ovf(err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_beat(input int first);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(first + i);
        return v;
    endfunction

    // Expected entries for both instances; the final beat differs in mask only.
    task automatic pushBeat(input logic [4:0] pid, input logic [DW-1:0] beat, input bit last);
        wr_exp_t e10, e16;
        done_exp_t d;
        e10.en   = last ? 2'b01 : 2'b11;
        e10.pid  = {pid, pid};
        e10.data = last ? (beat & MASK10) : beat;
        e10.last = last ? 2'b01 : 2'b00;
        e10.cyc  = cycle_cnt + 1;
        e16      = e10;
        e16.en   = 2'b11;
        e16.data = beat;
        q10.push_back(e10);
        q16.push_back(e16);
        if (last) begin
            d.pid = pid;
            d.cyc = cycle_cnt + 1;
            dq10.push_back(d);
            dq16.push_back(d);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] pid, input int first, input bit hold_vld, input bit stall);
        int w = 0;
        int b = 0;
        int cyc = 0;
        @(negedge clk);
        cmd_pid = pid;
        cmd_vld = 1'b1;
        in_data = make_beat(first);
        if (hold_vld) in_vld = 1'b1;
        while (!cmd_rdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_rdy) begin
            checkOutput("cmd_accept_timeout", 0, 1);
            cmd_vld = 1'b0;
            return;
        end
        while (b < 2 && cyc < 40) begin
            @(negedge clk);
            cmd_vld = 1'b0;
            in_data = make_beat(first + 8 * b);
            in_vld  = stall ? (cyc % 2 == 0) : 1'b1;
            if (in_vld && in_rdy) begin
                pushBeat(pid, in_data, b == 1);
                b++;
            end
            cyc++;
        end
        if (b < 2) checkOutput("beat_accept_timeout", b, 2);
        if (!hold_vld) begin
            @(negedge clk);
            in_vld = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        wr_exp_t e;
        done_exp_t d;
        if (wen10 != 2'b00) begin
            if (q10.size() == 0) checkOutput("unexpected_write10", wen10, 0);
            else begin
                e = q10.pop_front();
                checkOutput("wr_en10", wen10, e.en);
                checkOutput("wr_pid10", wpid10, e.pid);
                checkOutput("wr_data10", wdata10, e.data);
                checkOutput("wr_pbs_last10", wlast10, e.last);
                checkOutput("wr_cycle10", cycle_cnt, e.cyc);
            end
        end
        if (done10 == 1'b1) begin
            done_cycles.push_back(cycle_cnt);
            if (dq10.size() == 0) checkOutput("unexpected_done10", done10, 0);
            else begin
                d = dq10.pop_front();
                checkOutput("done_pid10", dpid10, d.pid);
                checkOutput("done_cycle10", cycle_cnt, d.cyc);
            end
        end
    end

    always @(negedge clk) begin
        wr_exp_t e;
        done_exp_t d;
        if (wen16 != 2'b00) begin
            if (q16.size() == 0) checkOutput("unexpected_write16", wen16, 0);
            else begin
                e = q16.pop_front();
                checkOutput("wr_en16", wen16, e.en);
                checkOutput("wr_pid16", wpid16, e.pid);
                checkOutput("wr_data16", wdata16, e.data);
                checkOutput("wr_pbs_last16", wlast16, e.last);
                checkOutput("wr_cycle16", cycle_cnt, e.cyc);
            end
        end
        if (done16 == 1'b1) begin
            if (dq16.size() == 0) checkOutput("unexpected_done16", done16, 0);
            else begin
                d = dq16.pop_front();
                checkOutput("done_pid16", dpid16, d.pid);
                checkOutput("done_cycle16", cycle_cnt, d.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle_cnt);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        s_rst_n = 1'b0;
        cmd_pid = '0;
        cmd_vld = 1'b0;
        in_data = '0;
        in_vld  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_rdy", cmd_rdy, 0);
        checkOutput("rst_in_rdy", in_rdy, 0);
        checkOutput("rst_wr_en", wen10, 0);
        checkOutput("rst_wr_pid", wpid10, 0);
        checkOutput("rst_wr_data", wdata10, 0);
        checkOutput("rst_pbs_last", wlast10, 0);
        checkOutput("rst_done", done10, 0);
        checkOutput("rst_done_pid", dpid10, 0);
        checkOutput("rst_error", err10, 0);
        s_rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_cmd_rdy", cmd_rdy, 1);
        checkOutput("post_rst_in_rdy", in_rdy, 0);

        $display("[TB] single load PID 3");
        applyStimulus(5'd3, 1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("single_error", err10, 0);

        $display("[TB] input stall PID 7");
        applyStimulus(5'd7, 101, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("stall_error", err10, 0);

        $display("[TB] back-to-back PIDs 1,2,3");
        done_cycles.delete();
        applyStimulus(5'd1, 201, 1'b1, 1'b0);
        applyStimulus(5'd2, 301, 1'b1, 1'b0);
        applyStimulus(5'd3, 401, 1'b1, 1'b0);
        @(negedge clk);
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("b2b_done_count", done_cycles.size(), 3);
        if (done_cycles.size() == 3) begin
            checkOutput("b2b_spacing_1", done_cycles[1] - done_cycles[0], 4);
            checkOutput("b2b_spacing_2", done_cycles[2] - done_cycles[1], 4);
        end
        checkOutput("b2b_error_sticky", err10, 1);

        $display("[TB] reset after first beat of PID 5");
        @(negedge clk);
        cmd_pid = 5'd5;
        cmd_vld = 1'b1;
        begin
            int w = 0;
            while (!cmd_rdy && w < 20) begin
                @(negedge clk);
                w++;
            end
        end
        checkOutput("rst_test_cmd_rdy", cmd_rdy, 1);
        @(negedge clk);
        cmd_vld = 1'b0;
        in_vld  = 1'b1;
        in_data = make_beat(601);
        checkOutput("rst_test_in_rdy", in_rdy, 1);
        if (in_rdy) pushBeat(5'd5, in_data, 1'b0);
        @(negedge clk);
        in_data = make_beat(609);
        s_rst_n = 1'b0;
        @(negedge clk);
        in_vld = 1'b0;
        checkOutput("midrst_cmd_rdy", cmd_rdy, 0);
        checkOutput("midrst_in_rdy", in_rdy, 0);
        checkOutput("midrst_error", err10, 0);
        @(negedge clk);
        s_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(5'd6, 701, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] stray data with no command");
        in_data = make_beat(801);
        in_vld  = 1'b1;
        @(negedge clk);
        checkOutput("stray_in_rdy", in_rdy, 0);
        checkOutput("stray_error_set", err10, 1);
        @(negedge clk);
        in_vld = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stray_error_held", err10, 1);
        checkOutput("stray_in_rdy_idle", in_rdy, 0);

        checkOutput("sb_empty10", q10.size(), 0);
        checkOutput("sb_empty16", q16.size(), 0);
        checkOutput("done_sb_empty10", dq10.size(), 0);
        checkOutput("done_sb_empty16", dq16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
